riscv_regfile_mp: RTL and testbench
===================================

# riscv_regfile_mp

Parametrised multi-port integer register file for the RISC-V core, generalising the fixed 3-read/2-write, 32 x 32-bit file to configurable width, depth and port counts. It adds deterministic write-port priority, write-collision reporting, and a per-register pending scoreboard. An optional same-cycle write-to-read bypass is compiled in by macro. It sits between decode (reads, reservations) and writeback (writes).

## Interface
- ADDR_WIDTH, 5: register index width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32: register width.
- NUM_READ, 3: read port count, 1..8.
- NUM_WRITE, 2: write port count, 1..4.
- ZERO_REG, 1: 1 = register 0 hardwired to zero, never written, never pending.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- raddr_i  in  NUM_READ x ADDR_WIDTH  read addresses.
- rdata_o  out  NUM_READ x DATA_WIDTH  read data, combinational.
- busy_o  out  NUM_READ  pending flag of the register addressed on each read port.
- waddr_i  in  NUM_WRITE x ADDR_WIDTH  write addresses.
- wdata_i  in  NUM_WRITE x DATA_WIDTH  write data.
- we_i  in  NUM_WRITE  write enables.
- rsv_valid_i  in  1  reserve request: mark rsv_addr_i pending.
- rsv_addr_i  in  ADDR_WIDTH  register to reserve.
- conflict_o  out  1  registered write-collision flag.

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops plus pend[] bit per register.
- Write: on rising clk, each register takes wdata from the highest-index port p with we_i[p]=1 and waddr_i[p] equal to its index. Lower-index ports to the same address are discarded.
- ZERO_REG=1: writes and reservations to address 0 are ignored; rdata for address 0 = 0; busy for address 0 = 0.
- Read: rdata_o[k] = contents[raddr_i[k]] as held before the current edge (see Configuration for bypass).
- Scoreboard:
  - rsv_valid_i sets pend[rsv_addr_i] at the edge.
  - Any accepted write clears pend[waddr].
  - Same-cycle reserve and write to the same address: reserve wins, so pend = 1 (new producer).
- busy_o[k] = pend[raddr_i[k]] (registered state, combinational select).
- Collision: conflict_o is set at the edge if, in the preceding cycle, two or more enabled write ports shared an address. Address 0 is excluded when ZERO_REG=1. Otherwise conflict_o is cleared. The flag is informational only; the write still resolves by priority.
- Reset (asynchronous, rst_n=0): all registers 0, all pend 0, conflict_o 0. Hence rdata_o = 0 and busy_o = 0 throughout reset. A write or reserve in the cycle rst_n deasserts takes effect at the first edge with rst_n=1.

## Timing
- Write-to-read latency: 1 edge (0 with bypass).
- Reserve-to-busy latency: 1 edge.
- Write-to-busy-clear latency: 1 edge (0 with bypass).
- conflict_o: 1 cycle after the colliding cycle, held exactly 1 cycle per colliding cycle.
- Read path is combinational; no read enable and no read handshake.

## Configuration
- REGFILE_BYPASS_EN defined:
  - rdata_o[k] returns the winning same-cycle wdata when raddr_i[k] matches an enabled write; priority is the same as for storage.
  - busy_o[k] reads 0 when that write clears the register, unless the same address is also being reserved this cycle.
- REGFILE_BYPASS_EN undefined: reads and busy reflect pre-edge state only. No combinational path from wdata_i/we_i to outputs.

## Structure
- Package riscv_regfile_pkg: default ADDR_WIDTH/DATA_WIDTH/NUM_READ/NUM_WRITE localparams, typedefs reg_addr_t and reg_data_t.
- Sub-module riscv_regfile_wr_arb: for each write port, computes per-register winning enable, data and collision detect. It is reused by the bypass muxes.

## Test plan
- Reset: write 0xDEADBEEF to r5, assert rst_n=0 mid-cycle -> rdata for r5 = 0 immediately, busy_o = 0, conflict_o = 0.
- Priority: W0 (r7, 0x1111) and W1 (r7, 0x2222) in the same cycle -> r7 = 0x2222 next cycle; conflict_o = 1 for exactly one cycle.
- Zero register: W0 writes r0 = 0xFFFFFFFF while reserving r0 -> rdata for r0 = 0, busy = 0, conflict_o = 0.
- Scoreboard: reserve r3, next cycle busy = 1. Then write r3 = 0x42 -> busy = 0 and rdata = 0x42 the following cycle. Reserve plus write r3 in the same cycle -> busy stays 1.
- Bypass (REGFILE_BYPASS_EN): read r9 while writing r9 = 0xA5A5A5A5 -> rdata = 0xA5A5A5A5 in the same cycle. Without the macro -> old value, new value next cycle.
- Configuration sweep: NUM_READ=6, NUM_WRITE=4, ADDR_WIDTH=6, DATA_WIDTH=64. Random writes to all 64 registers checked against a reference-model array on every read port.

Source files
------------

// File: rtl/riscv_regfile_mp_pkg.sv
// riscv_regfile_pkg: default geometry and shared typedefs for the multi-port
// integer register file.
package riscv_regfile_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_NUM_READ   = 3;
  localparam int unsigned RF_NUM_WRITE  = 2;

  typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/riscv_regfile_mp_if.sv
// riscv_regfile_mp_if: read, write and reservation bus of the register file.
// The master side is decode/writeback; the slave side is the register file.
interface riscv_regfile_mp_if
  import riscv_regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned NUM_READ   = RF_NUM_READ,
  parameter int unsigned NUM_WRITE  = RF_NUM_WRITE
);

  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  raddr_i;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdata_o;
  logic [NUM_READ-1:0]                  busy_o;
  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] waddr_i;
  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NUM_WRITE-1:0]                 we_i;
  logic                                 rsv_valid_i;
  logic [ADDR_WIDTH-1:0]                rsv_addr_i;
  logic                                 conflict_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i, rsv_valid_i, rsv_addr_i,
    input  rdata_o, busy_o, conflict_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i, rsv_valid_i, rsv_addr_i,
    output rdata_o, busy_o, conflict_o
  );

endinterface

// File: rtl/riscv_regfile_mp_wr_arb.sv
// riscv_regfile_wr_arb: resolves the write ports into one winning enable and
// data word per register (highest port index wins) and flags any pair of
// enabled ports sharing an address. Register 0 is excluded when ZERO_REG=1.
module riscv_regfile_wr_arb
  import riscv_regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned NUM_WRITE  = RF_NUM_WRITE,
  parameter bit          ZERO_REG   = 1'b1,
  localparam int unsigned DEPTH     = 2**ADDR_WIDTH
) (
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WRITE-1:0]                 we_i,
  output logic [DEPTH-1:0]                     win_en_o,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0]     win_data_o,
  output logic                                 collision_o
);

  // Per-register winner: ascending port scan so the last match (highest index) sticks.
  always_comb begin
    win_en_o   = '0;
    win_data_o = '0;
    for (int unsigned r = 0; r < DEPTH; r++) begin
      for (int unsigned p = 0; p < NUM_WRITE; p++) begin
        if (we_i[p] && (waddr_i[p] == ADDR_WIDTH'(r)) && !(ZERO_REG && (r == 0))) begin
          win_en_o[r]   = 1'b1;
          win_data_o[r] = wdata_i[p];
        end
      end
    end
  end

  // Pairwise address compare across enabled write ports.
  always_comb begin
    collision_o = 1'b0;
    for (int unsigned i = 0; i < NUM_WRITE; i++) begin
      for (int unsigned j = i + 1; j < NUM_WRITE; j++) begin
        if (we_i[i] && we_i[j] && (waddr_i[i] == waddr_i[j]) &&
            !(ZERO_REG && (waddr_i[i] == '0))) begin
          collision_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/riscv_regfile_mp.sv
// riscv_regfile_mp: parametrised multi-port integer register file with
// priority-resolved writes, registered write-collision flag and a per-register
// pending scoreboard. Optional same-cycle write-to-read bypass is compiled in
// with the REGFILE_BYPASS_EN macro.
module riscv_regfile_mp
  import riscv_regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned NUM_READ   = RF_NUM_READ,
  parameter int unsigned NUM_WRITE  = RF_NUM_WRITE,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  riscv_regfile_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]    mem_q;
  logic [DEPTH-1:0]                    pend_q;
  logic                                conflict_q;

  logic [DEPTH-1:0]                    win_en;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]    win_data;
  logic                                collision;

  logic [NUM_READ-1:0][DATA_WIDTH-1:0] rdata;
  logic [NUM_READ-1:0]                 busy;

  riscv_regfile_wr_arb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WRITE  (NUM_WRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_wr_arb (
    .waddr_i     (bus.waddr_i),
    .wdata_i     (bus.wdata_i),
    .we_i        (bus.we_i),
    .win_en_o    (win_en),
    .win_data_o  (win_data),
    .collision_o (collision)
  );

  // Register storage: each register takes its arbitrated write data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (win_en[r]) begin
          mem_q[r] <= win_data[r];
        end
      end
    end
  end

  // Pending scoreboard: a reservation outranks a same-cycle clearing write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (bus.rsv_valid_i && (bus.rsv_addr_i == ADDR_WIDTH'(r)) &&
            !(ZERO_REG && (r == 0))) begin
          pend_q[r] <= 1'b1;
        end else if (win_en[r]) begin
          pend_q[r] <= 1'b0;
        end
      end
    end
  end

  // Collision flag: one-cycle registered copy of the arbiter's detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= collision;
    end
  end

  // Read ports: combinational select of stored state, optionally bypassed.
  always_comb begin
    rdata = '0;
    busy  = '0;
    for (int unsigned k = 0; k < NUM_READ; k++) begin
      rdata[k] = mem_q[bus.raddr_i[k]];
      busy[k]  = pend_q[bus.raddr_i[k]];
`ifdef REGFILE_BYPASS_EN
      // The arbiter already masks register 0, so the bypass never exposes it.
      if (win_en[bus.raddr_i[k]]) begin
        rdata[k] = win_data[bus.raddr_i[k]];
        if (!(bus.rsv_valid_i && (bus.rsv_addr_i == bus.raddr_i[k]))) begin
          busy[k] = 1'b0;
        end
      end
`endif
    end
  end

  assign bus.rdata_o    = rdata;
  assign bus.busy_o     = busy;
  assign bus.conflict_o = conflict_q;

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// tb_riscv_regfile_mp: directed checks on the default 3R/2W configuration and
// a reference-model sweep on a 6R/4W, 64 x 64-bit instance.
module tb_riscv_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  riscv_regfile_mp_if #(
    .ADDR_WIDTH (5), .DATA_WIDTH (32), .NUM_READ (3), .NUM_WRITE (2)
  ) d_if ();

  riscv_regfile_mp_if #(
    .ADDR_WIDTH (6), .DATA_WIDTH (64), .NUM_READ (6), .NUM_WRITE (4)
  ) s_if ();

  riscv_regfile_mp #(
    .ADDR_WIDTH (5), .DATA_WIDTH (32), .NUM_READ (3), .NUM_WRITE (2), .ZERO_REG (1'b1)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (d_if.slave)
  );

  riscv_regfile_mp #(
    .ADDR_WIDTH (6), .DATA_WIDTH (64), .NUM_READ (6), .NUM_WRITE (4), .ZERO_REG (1'b1)
  ) u_dut_sweep (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_d();
    d_if.we_i        = '0;
    d_if.rsv_valid_i = 1'b0;
  endtask

  logic [63:0] mref [64];
  logic        exp_conf;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    d_if.raddr_i = '0; d_if.waddr_i = '0; d_if.wdata_i = '0; d_if.we_i = '0;
    d_if.rsv_valid_i = 1'b0; d_if.rsv_addr_i = '0;
    s_if.raddr_i = '0; s_if.waddr_i = '0; s_if.wdata_i = '0; s_if.we_i = '0;
    s_if.rsv_valid_i = 1'b0; s_if.rsv_addr_i = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset: colliding write + reserve on r5, then mid-cycle reset clears all.
    d_if.waddr_i[0] = 5'd5; d_if.wdata_i[0] = 32'h0000_0BAD; d_if.we_i[0] = 1'b1;
    d_if.waddr_i[1] = 5'd5; d_if.wdata_i[1] = 32'hDEAD_BEEF; d_if.we_i[1] = 1'b1;
    d_if.rsv_valid_i = 1'b1; d_if.rsv_addr_i = 5'd5;
    d_if.raddr_i[0] = 5'd5;
    tick(); clr_d(); #1;
    check("pre_rst_rdata", d_if.rdata_o[0], 64'hDEAD_BEEF);
    check("pre_rst_busy", d_if.busy_o[0], 1);
    check("pre_rst_conflict", d_if.conflict_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rdata", d_if.rdata_o[0], 0);
    check("rst_busy", d_if.busy_o[0], 0);
    check("rst_conflict", d_if.conflict_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Priority: both ports write r7, port 1 wins, conflict for one cycle.
    d_if.waddr_i[0] = 5'd7; d_if.wdata_i[0] = 32'h1111; d_if.we_i[0] = 1'b1;
    d_if.waddr_i[1] = 5'd7; d_if.wdata_i[1] = 32'h2222; d_if.we_i[1] = 1'b1;
    d_if.raddr_i[1] = 5'd7;
    #1;
    check("prio_pre_edge", d_if.rdata_o[1], BYP ? 64'h2222 : 64'h0);
    check("prio_pre_conflict", d_if.conflict_o, 0);
    tick(); clr_d(); #1;
    check("prio_rdata", d_if.rdata_o[1], 64'h2222);
    check("prio_conflict_set", d_if.conflict_o, 1);
    tick();
    check("prio_conflict_clr", d_if.conflict_o, 0);

    // Distinct addresses: both writes land, no conflict.
    d_if.waddr_i[0] = 5'd8;  d_if.wdata_i[0] = 32'hAAAA_0008; d_if.we_i[0] = 1'b1;
    d_if.waddr_i[1] = 5'd11; d_if.wdata_i[1] = 32'hBBBB_000B; d_if.we_i[1] = 1'b1;
    d_if.raddr_i[0] = 5'd8; d_if.raddr_i[1] = 5'd11;
    tick(); clr_d(); #1;
    check("distinct_r8", d_if.rdata_o[0], 64'hAAAA_0008);
    check("distinct_r11", d_if.rdata_o[1], 64'hBBBB_000B);
    check("distinct_conflict", d_if.conflict_o, 0);

    // Same address but port 1 disabled: no collision, port 0 writes.
    d_if.waddr_i[0] = 5'd10; d_if.wdata_i[0] = 32'h5; d_if.we_i[0] = 1'b1;
    d_if.waddr_i[1] = 5'd10; d_if.wdata_i[1] = 32'h6; d_if.we_i[1] = 1'b0;
    d_if.raddr_i[0] = 5'd10;
    tick(); clr_d(); #1;
    check("disabled_rdata", d_if.rdata_o[0], 64'h5);
    check("disabled_conflict", d_if.conflict_o, 0);

    // Zero register: writes, collision and reserve on r0 are all ignored.
    d_if.waddr_i[0] = 5'd0; d_if.wdata_i[0] = 32'hFFFF_FFFF; d_if.we_i[0] = 1'b1;
    d_if.waddr_i[1] = 5'd0; d_if.wdata_i[1] = 32'h12;        d_if.we_i[1] = 1'b1;
    d_if.rsv_valid_i = 1'b1; d_if.rsv_addr_i = 5'd0;
    d_if.raddr_i[2] = 5'd0;
    #1;
    check("zero_pre_rdata", d_if.rdata_o[2], 0);
    tick(); clr_d(); #1;
    check("zero_rdata", d_if.rdata_o[2], 0);
    check("zero_busy", d_if.busy_o[2], 0);
    check("zero_conflict", d_if.conflict_o, 0);

    // Scoreboard: reserve, clear by write, then reserve+write keeps pending.
    d_if.raddr_i[0] = 5'd3;
    d_if.rsv_valid_i = 1'b1; d_if.rsv_addr_i = 5'd3;
    tick(); clr_d(); #1;
    check("sb_busy_set", d_if.busy_o[0], 1);
    check("sb_rdata_init", d_if.rdata_o[0], 0);
    d_if.waddr_i[0] = 5'd3; d_if.wdata_i[0] = 32'h42; d_if.we_i[0] = 1'b1;
    #1;
    check("sb_busy_pre_clear", d_if.busy_o[0], BYP ? 64'h0 : 64'h1);
    tick(); clr_d(); #1;
    check("sb_busy_clear", d_if.busy_o[0], 0);
    check("sb_rdata_42", d_if.rdata_o[0], 64'h42);
    d_if.waddr_i[1] = 5'd3; d_if.wdata_i[1] = 32'h43; d_if.we_i[1] = 1'b1;
    d_if.rsv_valid_i = 1'b1; d_if.rsv_addr_i = 5'd3;
    #1;
    check("sb_rsvwr_pre_busy", d_if.busy_o[0], 0);
    tick(); clr_d(); #1;
    check("sb_rsvwr_busy", d_if.busy_o[0], 1);
    check("sb_rsvwr_rdata", d_if.rdata_o[0], 64'h43);
    tick();
    check("sb_busy_hold", d_if.busy_o[0], 1);

    // Bypass: same-cycle read of r9 while writing it.
    d_if.waddr_i[0] = 5'd9; d_if.wdata_i[0] = 32'h1234_5678; d_if.we_i[0] = 1'b1;
    tick(); clr_d();
    d_if.waddr_i[0] = 5'd9; d_if.wdata_i[0] = 32'hA5A5_A5A5; d_if.we_i[0] = 1'b1;
    d_if.raddr_i[2] = 5'd9;
    #1;
    check("byp_same_cycle", d_if.rdata_o[2], BYP ? 64'hA5A5_A5A5 : 64'h1234_5678);
    tick(); clr_d(); #1;
    check("byp_next_cycle", d_if.rdata_o[2], 64'hA5A5_A5A5);

    // Sweep phase 1: fill all 64 registers, four per cycle.
    for (int i = 0; i < 64; i++) mref[i] = '0;
    for (int b = 0; b < 64; b += 4) begin
      for (int p = 0; p < 4; p++) begin
        s_if.waddr_i[p] = 6'(b + p);
        s_if.wdata_i[p] = {$urandom, $urandom};
        s_if.we_i[p]    = 1'b1;
        if (b + p != 0) mref[b + p] = s_if.wdata_i[p];
      end
      tick();
    end
    s_if.we_i = '0;
    for (int b = 0; b < 66; b += 6) begin
      for (int k = 0; k < 6; k++) s_if.raddr_i[k] = 6'((b + k) % 64);
      #1;
      for (int k = 0; k < 6; k++) begin
        check($sformatf("fill_r%0d", (b + k) % 64), s_if.rdata_o[k], mref[(b + k) % 64]);
      end
      tick();
    end

    // Sweep phase 2: random, frequently colliding writes on a narrow address range.
    for (int c = 0; c < 40; c++) begin
      exp_conf = 1'b0;
      for (int p = 0; p < 4; p++) begin
        s_if.we_i[p]    = 1'($urandom_range(0, 1));
        s_if.waddr_i[p] = 6'($urandom_range(0, 15) + ((c % 4) * 16));
        s_if.wdata_i[p] = {$urandom, $urandom};
      end
      for (int p = 0; p < 4; p++) begin
        if (s_if.we_i[p] && s_if.waddr_i[p] != 0) mref[s_if.waddr_i[p]] = s_if.wdata_i[p];
        for (int q = p + 1; q < 4; q++) begin
          if (s_if.we_i[p] && s_if.we_i[q] && s_if.waddr_i[p] == s_if.waddr_i[q] &&
              s_if.waddr_i[p] != 0) exp_conf = 1'b1;
        end
      end
      tick();
      s_if.we_i = '0;
      for (int k = 0; k < 6; k++) s_if.raddr_i[k] = 6'($urandom_range(0, 63));
      #1;
      for (int k = 0; k < 6; k++) begin
        check($sformatf("rand_c%0d_p%0d", c, k), s_if.rdata_o[k], mref[s_if.raddr_i[k]]);
      end
      check($sformatf("rand_conflict_c%0d", c), s_if.conflict_o, exp_conf);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
